// File: rtl/eth_pkg.sv
// Shared Ethernet constants and receive framer state encoding.
// Used by the GMII receive framer and the transmit FCS path.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

endpackage

// File: rtl/gmii_rx_frame_if.sv
// Payload byte stream leaving the receive framer.
// No back-pressure: the sink takes every beat.
interface gmii_rx_frame_if;

    logic       m_valid;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eof;
    logic       m_err;

    modport master (
        output m_valid, m_data, m_sof, m_eof, m_err
    );

    modport slave (
        input m_valid, m_data, m_sof, m_eof, m_err
    );

endinterface

// File: rtl/gmii_rx_frame_crc32_d8.sv
// Combinational reflected CRC-32 update, one byte LSB-first.
// No final XOR; the caller owns init and residue handling.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc_cur,
    output logic [31:0] crc_nxt
);

    logic [31:0] c;

    always_comb begin
        c = crc_cur;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
            else                c = c >> 1;
        end
        crc_nxt = c;
    end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC and
// length, emits payload with sof/eof/err and keeps frame statistics.
module gmii_rx_frame
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             gmii_rxc,
    input  logic             rst_n,
    input  logic             gmii_rx_en,
    input  logic [7:0]       gmii_rxd,
    gmii_rx_frame_if.master  m,
    output logic             stat_good,
    output logic             stat_bad,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [10:0] LEN_SAT = '1;
    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);

    rx_state_t       state_q, state_d;
    logic            start, push, fin, pre_end;
    logic [31:0]     crc_q, crc_nxt;
    logic [10:0]     len_q;
    logic [4:0][7:0] dly_q;
    logic            has_out, frame_bad, beat;
    logic            good_ev, bad_ev;

    crc32_d8 u_crc (
        .data    (gmii_rxd),
        .crc_cur (crc_q),
        .crc_nxt (crc_nxt)
    );

    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        push    = 1'b0;
        fin     = 1'b0;
        pre_end = 1'b0;
        unique case (state_q)
            WAIT_IDLE: begin
                if (!gmii_rx_en) state_d = IDLE;
            end
            IDLE: begin
                if (gmii_rx_en) begin
                    start = 1'b1;
                    if (gmii_rxd == PREAMBLE_BYTE) state_d = PRE;
                    else if (gmii_rxd == SFD_BYTE) state_d = DATA;
                    else                           state_d = DROP;
                end
            end
            PRE: begin
                if (!gmii_rx_en) begin
                    state_d = IDLE;
                    pre_end = 1'b1;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_d = DATA;
                end else if (gmii_rxd != PREAMBLE_BYTE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (gmii_rx_en) push = 1'b1;
                else begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (!gmii_rx_en) begin
                    state_d = IDLE;
                    pre_end = 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // The oldest delay-line byte is the next payload byte once 5 are held.
    assign has_out   = len_q >= 11'd5;
    assign beat      = (push || fin) && has_out;
    assign frame_bad = (crc_q != CRC32_RESIDUE) ||
                       (len_q < MIN_L) || (len_q > MAX_L);
    assign good_ev   = fin && has_out && !frame_bad;
    assign bad_ev    = pre_end || (fin && (!has_out || frame_bad));

    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC32_INIT;
            len_q <= '0;
            dly_q <= '0;
        end else if (start || fin) begin
            crc_q <= CRC32_INIT;
            len_q <= '0;
            dly_q <= '0;
        end else if (push) begin
            crc_q <= crc_nxt;
            if (len_q != LEN_SAT) len_q <= len_q + 11'd1;
            dly_q <= {dly_q[3:0], gmii_rxd};
        end
    end

    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
            m.m_sof   <= 1'b0;
            m.m_eof   <= 1'b0;
            m.m_err   <= 1'b0;
            stat_good <= 1'b0;
            stat_bad  <= 1'b0;
        end else begin
            m.m_valid <= beat;
            m.m_sof   <= beat && (len_q == 11'd5);
            m.m_eof   <= fin && has_out;
            m.m_err   <= fin && has_out && frame_bad;
            if (beat) m.m_data <= dly_q[4];
            stat_good <= good_ev;
            stat_bad  <= bad_ev;
        end
    end

    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (good_ev && good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
            if (bad_ev && bad_cnt != '1)   bad_cnt  <= bad_cnt + CNT_W'(1);
        end
    end

endmodule
